// File: rtl/sp_wb_collector.sv
// sp_wb_collector: program-ordered writeback queue between the SP/int-multiply
// pipe and the register file. It captures the stage-6 FP result and the stage-7
// integer result, and drains one entry per cycle into the RF write port.
// Operand lookups see pending values, so dependent instructions are never
// served stale register data.
module sp_wb_collector #(
    parameter int DEPTH     = 4,
    parameter int STALL_LVL = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [0:127]             rt_wb,
    input  logic [0:6]               rt_addr_wb,
    input  logic                     reg_write_wb,
    input  logic [0:127]             rt_int,
    input  logic [0:6]               rt_addr_int,
    input  logic                     reg_write_int,
    output logic                     rf_wr_en,
    output logic [0:6]               rf_wr_addr,
    output logic [0:127]             rf_wr_data,
    input  logic                     rf_wr_ready,
    input  logic [0:6]               fwd_addr_a,
    input  logic [0:6]               fwd_addr_b,
    input  logic [0:6]               fwd_addr_c,
    output logic                     fwd_hit_a,
    output logic                     fwd_hit_b,
    output logic                     fwd_hit_c,
    output logic [0:127]             fwd_data_a,
    output logic [0:127]             fwd_data_b,
    output logic [0:127]             fwd_data_c,
    output logic                     stall,
    output logic [0:$clog2(DEPTH)]   count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);
    localparam logic [CW:0] STALL_X = (CW+1)'(STALL_LVL);

    logic [0:6]    addr_q [DEPTH];
    logic [0:6]    addr_d [DEPTH];
    logic [0:127]  data_q [DEPTH];
    logic [0:127]  data_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          deq;
    logic [CW:0]   avail;
    logic          acc_int;
    logic          acc_wb;
    logic [PW-1:0] wb_slot;

    logic [0:6]    lk_addr [3];
    logic          lk_hit  [3];
    logic [0:127]  lk_data [3];
    logic [PW-1:0] fwd_idx;

    // Admission, ordering and pointer/occupancy update for the queue.
    always_comb begin
        deq     = (count_q != '0) && rf_wr_ready;
        // A same-cycle retire frees its slot for this cycle's inputs.
        avail   = DEPTH_X - {1'b0, count_q} + {{CW{1'b0}}, deq};
        // The int result is the older instruction: it claims space first,
        // so when room is short the FP result is the one dropped.
        acc_int = reg_write_int && (avail != '0);
        acc_wb  = reg_write_wb && (avail > {{CW{1'b0}}, acc_int});
        wb_slot = acc_int ? (tail_q + PW'(1)) : tail_q;

        addr_d = addr_q;
        data_d = data_q;
        if (acc_int) begin
            addr_d[tail_q] = rt_addr_int;
            data_d[tail_q] = rt_int;
        end
        if (acc_wb) begin
            addr_d[wb_slot] = rt_addr_wb;
            data_d[wb_slot] = rt_wb;
        end

        tail_d  = tail_q + PW'(acc_int) + PW'(acc_wb);
        head_d  = head_q + PW'(deq);
        count_d = count_q + CW'(acc_int) + CW'(acc_wb) - CW'(deq);
        ovf_d   = ovf_q | (reg_write_int & ~acc_int) | (reg_write_wb & ~acc_wb);
    end

    // Queue state; reset discards all contents at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Head offer and status, all derived from registered state.
    always_comb begin
        rf_wr_en   = (count_q != '0);
        rf_wr_addr = rf_wr_en ? addr_q[head_q] : '0;
        rf_wr_data = rf_wr_en ? data_q[head_q] : '0;
        stall      = (DEPTH_X - {1'b0, count_q}) <= STALL_X;
        count      = count_q;
        overflow   = ovf_q;
    end

    assign lk_addr[0] = fwd_addr_a;
    assign lk_addr[1] = fwd_addr_b;
    assign lk_addr[2] = fwd_addr_c;

    // Forwarding lookup: scan oldest to youngest so the youngest match wins,
    // then let the int input and finally the FP input override.
    always_comb begin
        fwd_idx = '0;
        for (int p = 0; p < 3; p++) begin
            lk_hit[p]  = 1'b0;
            lk_data[p] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                fwd_idx = head_q + PW'(i);
                if ((CW'(i) < count_q) && (addr_q[fwd_idx] == lk_addr[p])) begin
                    lk_hit[p]  = 1'b1;
                    lk_data[p] = data_q[fwd_idx];
                end
            end
            if (reg_write_int && (rt_addr_int == lk_addr[p])) begin
                lk_hit[p]  = 1'b1;
                lk_data[p] = rt_int;
            end
            if (reg_write_wb && (rt_addr_wb == lk_addr[p])) begin
                lk_hit[p]  = 1'b1;
                lk_data[p] = rt_wb;
            end
        end
    end

    assign fwd_hit_a  = lk_hit[0];
    assign fwd_hit_b  = lk_hit[1];
    assign fwd_hit_c  = lk_hit[2];
    assign fwd_data_a = lk_data[0];
    assign fwd_data_b = lk_data[1];
    assign fwd_data_c = lk_data[2];

endmodule

// File: tb/tb_sp_wb_collector.sv
// Bench for sp_wb_collector: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_sp_wb_collector;

    localparam int DEPTH     = 4;
    localparam int STALL_LVL = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [0:127] rt_wb = '0;
    logic [0:6]   rt_addr_wb = '0;
    logic         reg_write_wb = 1'b0;
    logic [0:127] rt_int = '0;
    logic [0:6]   rt_addr_int = '0;
    logic         reg_write_int = 1'b0;
    logic         rf_wr_en;
    logic [0:6]   rf_wr_addr;
    logic [0:127] rf_wr_data;
    logic         rf_wr_ready = 1'b0;
    logic [0:6]   fwd_addr_a = '0;
    logic [0:6]   fwd_addr_b = '0;
    logic [0:6]   fwd_addr_c = '0;
    logic         fwd_hit_a, fwd_hit_b, fwd_hit_c;
    logic [0:127] fwd_data_a, fwd_data_b, fwd_data_c;
    logic         stall;
    logic [0:2]   count;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    sp_wb_collector #(.DEPTH(DEPTH), .STALL_LVL(STALL_LVL)) dut (
        .clk(clk), .reset(reset),
        .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb),
        .rt_int(rt_int), .rt_addr_int(rt_addr_int), .reg_write_int(reg_write_int),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .rf_wr_ready(rf_wr_ready),
        .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b), .fwd_addr_c(fwd_addr_c),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b), .fwd_hit_c(fwd_hit_c),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b), .fwd_data_c(fwd_data_c),
        .stall(stall), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] dv(input int a);
        return {4{32'(a) ^ 32'h5A5A_0000}};
    endfunction

    // Reference model: an ordered list of pending results.
    typedef struct packed {
        logic [6:0]   a;
        logic [127:0] d;
    } ent_t;

    ent_t       mq[$];
    logic       m_ovf = 1'b0;
    logic [6:0] wlog[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            int   room;
            bit   retire;
            ent_t e;
            retire = (mq.size() != 0) && rf_wr_ready;
            room   = DEPTH - mq.size() + (retire ? 1 : 0);
            if (retire) void'(mq.pop_front());
            if (reg_write_int) begin
                if (room > 0) begin
                    e.a = rt_addr_int; e.d = rt_int;
                    mq.push_back(e);
                    room--;
                end else m_ovf = 1'b1;
            end
            if (reg_write_wb) begin
                if (room > 0) begin
                    e.a = rt_addr_wb; e.d = rt_wb;
                    mq.push_back(e);
                    room--;
                end else m_ovf = 1'b1;
            end
        end
    end

    function automatic void mfwd(input logic [6:0] a, output logic h, output logic [127:0] d);
        h = 1'b0;
        d = '0;
        if (reg_write_wb && rt_addr_wb == a) begin h = 1'b1; d = rt_wb; return; end
        if (reg_write_int && rt_addr_int == a) begin h = 1'b1; d = rt_int; return; end
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == a) begin h = 1'b1; d = mq[i].d; return; end
        end
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic         h;
        logic [127:0] d;
        logic         en_e;
        en_e = (mq.size() != 0);
        chk("rf_wr_en", rf_wr_en, en_e);
        chk("rf_wr_addr", rf_wr_addr, en_e ? mq[0].a : 7'd0);
        chk("rf_wr_data", rf_wr_data, en_e ? mq[0].d : 128'd0);
        chk("count", count, mq.size());
        chk("stall", stall, (DEPTH - mq.size()) <= STALL_LVL);
        chk("overflow", overflow, m_ovf);
        mfwd(fwd_addr_a, h, d);
        chk("fwd_hit_a", fwd_hit_a, h);
        chk("fwd_data_a", fwd_data_a, d);
        mfwd(fwd_addr_b, h, d);
        chk("fwd_hit_b", fwd_hit_b, h);
        chk("fwd_data_b", fwd_data_b, d);
        mfwd(fwd_addr_c, h, d);
        chk("fwd_hit_c", fwd_hit_c, h);
        chk("fwd_data_c", fwd_data_c, d);
        if (reset && rf_wr_en && rf_wr_ready) wlog.push_back(rf_wr_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit iv, input logic [6:0] ia, input logic [127:0] id,
                          input bit wv, input logic [6:0] wa, input logic [127:0] wd);
        reg_write_int = iv; rt_addr_int = ia; rt_int = id;
        reg_write_wb  = wv; rt_addr_wb  = wa; rt_wb  = wd;
    endtask

    task automatic clr_in();
        set_in(1'b0, 7'd0, 128'd0, 1'b0, 7'd0, 128'd0);
    endtask

    initial begin
        logic [127:0] va, vb;
        #1 reset = 1'b0;
        #1;
        chk("rst_en", rf_wr_en, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single int result, immediately drained.
        rf_wr_ready = 1'b1;
        fwd_addr_a = 7'd5;
        set_in(1'b1, 7'd5, {4{32'h0000_0006}}, 1'b0, 7'd0, 128'd0);
        #1;
        chk("t1_fwd_in_hit", fwd_hit_a, 1'b1);
        chk("t1_fwd_in_data", fwd_data_a, {4{32'h0000_0006}});
        tick();
        clr_in();
        #1;
        chk("t1_en", rf_wr_en, 1'b1);
        chk("t1_addr", rf_wr_addr, 7'd5);
        chk("t1_fwd_q_hit", fwd_hit_a, 1'b1);
        tick();
        chk("t1_count0", count, 3'd0);

        // Same-register int and FP in one cycle.
        va = {4{32'hAAAA_0001}};
        vb = {4{32'hBBBB_0002}};
        rf_wr_ready = 1'b0;
        fwd_addr_a = 7'd3;
        set_in(1'b1, 7'd3, va, 1'b1, 7'd3, vb);
        #1;
        chk("t2_fwd_in", fwd_data_a, vb);
        tick();
        clr_in();
        #1;
        chk("t2_count", count, 3'd2);
        chk("t2_head_A", rf_wr_data, va);
        chk("t2_fwd_q", fwd_data_a, vb);
        rf_wr_ready = 1'b1;
        tick();
        chk("t2_head_B_addr", rf_wr_addr, 7'd3);
        chk("t2_head_B", rf_wr_data, vb);
        tick();
        chk("t2_empty", rf_wr_en, 1'b0);

        // Fill with paired results until results are dropped.
        rf_wr_ready = 1'b0;
        fwd_addr_a = 7'd0;
        set_in(1'b1, 7'd10, dv(10), 1'b1, 7'd11, dv(11));
        tick();
        chk("t3_count2", count, 3'd2);
        chk("t3_stall", stall, 1'b1);
        set_in(1'b1, 7'd12, dv(12), 1'b1, 7'd13, dv(13));
        tick();
        chk("t3_count4", count, 3'd4);
        chk("t3_noovf", overflow, 1'b0);
        set_in(1'b1, 7'd14, dv(14), 1'b1, 7'd15, dv(15));
        tick();
        chk("t3_count_full", count, 3'd4);
        chk("t3_ovf", overflow, 1'b1);
        clr_in();
        tick();
        chk("t3_ovf_sticky", overflow, 1'b1);
        chk("t3_head", rf_wr_addr, 7'd10);

        // Drain one, then assert reset between edges.
        rf_wr_ready = 1'b1;
        tick();
        rf_wr_ready = 1'b0;
        chk("t5_count3", count, 3'd3);
        #1 reset = 1'b0;
        #1;
        chk("t5_en", rf_wr_en, 1'b0);
        chk("t5_count", count, 3'd0);
        chk("t5_stall", stall, 1'b0);
        chk("t5_ovf", overflow, 1'b0);
        tick();
        reset = 1'b1;
        rf_wr_ready = 1'b1;
        set_in(1'b1, 7'd7, dv(7), 1'b0, 7'd0, 128'd0);
        tick();
        clr_in();
        chk("t5_new_addr", rf_wr_addr, 7'd7);
        chk("t5_new_data", rf_wr_data, dv(7));
        chk("t5_new_count", count, 3'd1);
        tick();
        chk("t5_drained", count, 3'd0);

        // Full queue with streaming single inputs: wrap and order.
        rf_wr_ready = 1'b0;
        wlog.delete();
        set_in(1'b1, 7'd30, dv(30), 1'b1, 7'd31, dv(31));
        tick();
        set_in(1'b1, 7'd32, dv(32), 1'b1, 7'd33, dv(33));
        tick();
        rf_wr_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_in(1'b1, 7'(40 + k), dv(40 + k), 1'b0, 7'd0, 128'd0);
            tick();
            if (k == 0) begin
                chk("t4_count_held", count, 3'd4);
                chk("t4_no_ovf", overflow, 1'b0);
            end
        end
        clr_in();
        for (int k = 0; k < 5; k++) tick();
        chk("t4_count0", count, 3'd0);
        chk("t4_ovf_end", overflow, 1'b0);
        chk("t4_nwrites", wlog.size(), 14);
        for (int i = 0; i < 14 && i < wlog.size(); i++) begin
            chk("t4_order", wlog[i], (i < 4) ? 7'(30 + i) : 7'(36 + i));
        end

        // Lookups: miss, then three independent ports.
        rf_wr_ready = 1'b0;
        fwd_addr_a = 7'd99;
        #1;
        chk("t6_miss_hit", fwd_hit_a, 1'b0);
        chk("t6_miss_data", fwd_data_a, 128'd0);
        set_in(1'b1, 7'd50, dv(50), 1'b0, 7'd0, 128'd0);
        tick();
        set_in(1'b1, 7'd51, dv(51), 1'b1, 7'd52, dv(52));
        fwd_addr_a = 7'd50;
        fwd_addr_b = 7'd51;
        fwd_addr_c = 7'd52;
        #1;
        chk("t6_a", fwd_data_a, dv(50));
        chk("t6_b", fwd_data_b, dv(51));
        chk("t6_c", fwd_data_c, dv(52));
        chk("t6_hit_a", fwd_hit_a, 1'b1);
        tick();
        clr_in();
        fwd_addr_a = 7'd51;
        fwd_addr_b = 7'd98;
        #1;
        chk("t6_q_a", fwd_data_a, dv(51));
        chk("t6_q_b_miss", fwd_hit_b, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
